// File: rtl/jk_mod_counter.sv
// jk_mod_counter: modulo-MODULUS counter whose state bits update through JK excitation.
// Optional up/down counting is enabled by defining JK_COUNTER_DOWN_EN; without it the counter counts up only.
module jk_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
`ifdef JK_COUNTER_DOWN_EN
    input  logic             up_i,
`endif
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             wrap_o,
    output logic [WIDTH-1:0] j_vec_o,
    output logic [WIDTH-1:0] k_vec_o
);

    if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_params
        $error("jk_mod_counter: illegal WIDTH/MODULUS combination");
    end

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_d, next_val, step_val;
    logic             wrap_q;
    logic             at_max, load_ok, tc_cond;

    assign at_max  = (count_q == MAX);
    assign load_ok = (32'(load_val_i) < MODULUS);

`ifdef JK_COUNTER_DOWN_EN
    logic at_zero;
    assign at_zero  = (count_q == '0);
    assign step_val = up_i ? (at_max ? '0 : count_q + WIDTH'(1))
                           : (at_zero ? MAX : count_q - WIDTH'(1));
    assign tc_cond  = up_i ? at_max : at_zero;
`else
    assign step_val = at_max ? '0 : count_q + WIDTH'(1);
    assign tc_cond  = at_max;
`endif

    // Pick the target state (load beats enable), derive JK excitation, then apply the JK bit equation.
    always_comb begin
        next_val = load_i ? (load_ok ? load_val_i : MAX) : (en_i ? step_val : count_q);
        j_vec_o  = next_val & ~count_q;
        k_vec_o  = ~next_val & count_q;
        count_d  = j_vec_o | (count_q & ~k_vec_o);
    end

    assign tc_o    = reset_ni & en_i & ~load_i & tc_cond;
    assign count_o = count_q;
    assign wrap_o  = wrap_q;

    // State flip-flops and the registered rollover pulse, cleared asynchronously.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= tc_o;
        end
    end

endmodule

// File: tb/tb_jk_mod_counter.sv
// tb_jk_mod_counter: directed self-checking bench for jk_mod_counter (WIDTH=4, MODULUS=10).
module tb_jk_mod_counter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic       load;
    logic [3:0] load_val;
    logic       up;
    logic [3:0] count, j_vec, k_vec;
    logic       tc, wrap;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk_i      (clk),
        .reset_ni   (reset_n),
        .en_i       (en),
        .load_i     (load),
        .load_val_i (load_val),
`ifdef JK_COUNTER_DOWN_EN
        .up_i       (up),
`endif
        .count_o    (count),
        .tc_o       (tc),
        .wrap_o     (wrap),
        .j_vec_o    (j_vec),
        .k_vec_o    (k_vec)
    );

    task automatic test_reset();
        reset_n = 1'b0; en = 1'b1; load = 1'b0; load_val = '0; up = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", wrap); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc got %b want 0", tc); end
        en = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic test_count();
        logic [3:0] exp, nxt;
        en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            exp = 4'(i % 10);
            nxt = (exp == 4'd9) ? 4'd0 : exp + 4'd1;
            checks++; if (count !== exp) begin errors++; $display("FAIL count_step%0d got %0d want %0d", i, count, exp); end
            checks++; if (tc !== (exp == 4'd9)) begin errors++; $display("FAIL count_tc%0d got %b want %b", i, tc, exp == 4'd9); end
            checks++; if (wrap !== (i == 10)) begin errors++; $display("FAIL count_wrap%0d got %b want %b", i, wrap, i == 10); end
            checks++; if (j_vec !== (nxt & ~exp) || k_vec !== (~nxt & exp)) begin
                errors++; $display("FAIL count_jk%0d got j=%b k=%b want j=%b k=%b", i, j_vec, k_vec, nxt & ~exp, ~nxt & exp);
            end
        end
    endtask

    task automatic test_hold();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (count !== 4'd6) begin errors++; $display("FAIL hold_count%0d got %0d want 6", i, count); end
            checks++; if (j_vec !== 4'd0 || k_vec !== 4'd0) begin errors++; $display("FAIL hold_jk%0d got j=%b k=%b want 0 0", i, j_vec, k_vec); end
            checks++; if (tc !== 1'b0) begin errors++; $display("FAIL hold_tc%0d got %b want 0", i, tc); end
        end
    endtask

    task automatic test_load();
        load = 1'b1; load_val = 4'd3; en = 1'b0;
        @(negedge clk);
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL load3 got %0d want 3", count); end
        load_val = 4'd7; en = 1'b1;
        #1;
        checks++; if (j_vec !== 4'b0100 || k_vec !== 4'b0000) begin errors++; $display("FAIL load7_jk got j=%b k=%b want 0100 0000", j_vec, k_vec); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL load7_tc got %b want 0", tc); end
        @(negedge clk);
        checks++; if (count !== 4'd7) begin errors++; $display("FAIL load7 got %0d want 7", count); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL load7_wrap got %b want 0", wrap); end
        load_val = 4'd13;
        @(negedge clk);
        checks++; if (count !== 4'd9) begin errors++; $display("FAIL load13_clamp got %0d want 9", count); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL load_at9_tc got %b want 0", tc); end
        load_val = 4'd10;
        @(negedge clk);
        checks++; if (count !== 4'd9) begin errors++; $display("FAIL load10_clamp got %0d want 9", count); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL load_at9_wrap got %b want 0", wrap); end
        load_val = 4'd9;
        @(negedge clk);
        checks++; if (count !== 4'd9) begin errors++; $display("FAIL load9 got %0d want 9", count); end
        load_val = 4'd0;
        @(negedge clk);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL load0 got %0d want 0", count); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL load0_wrap got %b want 0", wrap); end
        load = 1'b0; en = 1'b0;
    endtask

`ifdef JK_COUNTER_DOWN_EN
    task automatic test_down();
        load = 1'b1; load_val = 4'd1;
        @(negedge clk);
        load = 1'b0; en = 1'b1; up = 1'b0;
        #1;
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL down_tc_at1 got %b want 0", tc); end
        @(negedge clk);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL down_to0 got %0d want 0", count); end
        checks++; if (tc !== 1'b1) begin errors++; $display("FAIL down_tc_at0 got %b want 1", tc); end
        @(negedge clk);
        checks++; if (count !== 4'd9) begin errors++; $display("FAIL down_to9 got %0d want 9", count); end
        checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL down_wrap got %b want 1", wrap); end
        @(negedge clk);
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL down_to8 got %0d want 8", count); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL down_wrap_end got %b want 0", wrap); end
        en = 1'b0; up = 1'b1;
    endtask
`endif

    task automatic test_async_reset();
        load = 1'b1; load_val = 4'd9;
        @(negedge clk);
        load = 1'b0; en = 1'b1;
        @(negedge clk);
        checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL ar_wrap_pre got %b want 1", wrap); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL ar_wrap_clear got %b want 0", wrap); end
        @(negedge clk);
        reset_n = 1'b1;
        load = 1'b1; load_val = 4'd5;
        @(negedge clk);
        load = 1'b0;
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL ar_pre got %0d want 5", count); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL ar_count_clear got %0d want 0", count); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL ar_tc got %b want 0", tc); end
        @(negedge clk);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL ar_held got %0d want 0", count); end
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL ar_resume got %0d want 1", count); end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count();
        test_hold();
        test_load();
`ifdef JK_COUNTER_DOWN_EN
        test_down();
`endif
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jk_mod_counter.md
# jk_mod_counter

Parameterized modulo-M synchronous counter whose state bits are updated with JK flip-flop excitation (J/K per bit), the counting stage that consumes the master-slave JK flip-flop behaviour. It provides enable, parallel load, cascade terminal-count and a registered wrap pulse. Typical use is as a BCD/mod-N divider feeding downstream display and sequencing logic.

## Interface
- WIDTH, 4, counter width in bits; legal range 1..16
- MODULUS, 10, count sequence 0..MODULUS-1; legal range 2..2**WIDTH; an illegal value is an elaboration error
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- en  input  1  count enable
- load  input  1  synchronous parallel load, priority over en
- load_val  input  WIDTH  value captured on load
- up  input  1  direction, 1 = up, 0 = down; present only with JK_COUNTER_DOWN_EN
- count  output  WIDTH  current state (JK flip-flop Q outputs)
- tc  output  1  combinational terminal count, for cascading
- wrap  output  1  registered one-cycle pulse after a rollover
- j_vec  output  WIDTH  per-bit J excitation for the next edge
- k_vec  output  WIDTH  per-bit K excitation for the next edge

## Operation
- Reset (reset=0, asynchronous): count=0, wrap=0; tc forced 0 while reset is low; j_vec/k_vec follow from count=0 and inputs.
- Next-state selection per edge, in priority order:
  - load=1: next = load_val if load_val < MODULUS, else MODULUS-1 (clamped); en ignored; wrap not set.
  - en=1, up direction: next = (count==MODULUS-1) ? 0 : count+1.
  - en=1, down direction: next = (count==0) ? MODULUS-1 : count-1.
  - otherwise: next = count (hold).
- JK excitation, per bit i: j_vec[i] = next[i] & ~count[i]; k_vec[i] = ~next[i] & count[i]. Both are 0 for an unchanged bit. j_vec & k_vec is always 0 (no toggle-by-J=K=1).
- Bit update: count[i] <= j_vec[i] ? 1 : (k_vec[i] ? 0 : count[i]). The implementation uses this JK form, not a direct assignment of next.
- tc = reset & en & ~load & (up ? count==MODULUS-1 : count==0).
- wrap <= tc at every edge; i.e. wrap=1 for exactly the cycle after a rollover edge.
- Arithmetic in WIDTH bits; when MODULUS==2**WIDTH, up-wrap equals natural overflow. No out-of-range state is reachable.

## Timing
- Count latency: 1 edge from en/load to new count.
- tc: same cycle as the qualifying count/en (combinational, no register).
- wrap: 1 cycle after tc, 1 cycle wide; consecutive rollovers (MODULUS reached every cycle is impossible for MODULUS>=2) never merge.
- reset asserted mid-count: count and wrap clear immediately, without waiting for clk. Deassertion takes effect at the next rising edge; the first edge after release may count.
- load and en together: load wins, tc=0, no wrap.
- Direction change on the same edge as a count uses the new up value.

## Configuration
- JK_COUNTER_DOWN_EN defined: up port present, up/down counting as above.
- Not defined: up port absent, direction fixed to up, and all down-path logic is removed. tc = reset & en & ~load & (count==MODULUS-1).

## Test plan
- Reset then en=1, MODULUS=10, 12 edges -> count 1..9,0,1,2; tc=1 while count=9; wrap=1 only in the cycle when count=0.
- en=0 for 5 edges at count=6 -> count stays 6, j_vec=k_vec=0, tc=0.
- load=1, load_val=7, en=1 same edge at count=3 -> count=7, tc=0 in that cycle, wrap=0; j_vec=4'b0100, k_vec=0 before the edge.
- load_val=13 (MODULUS=10) -> count=9 (clamped).
- With JK_COUNTER_DOWN_EN, up=0, en=1 from count=1 -> 0, 9, 8; tc=1 at count=0; wrap pulse at count=9.
- reset low asynchronously between edges at count=5 -> count=0 and wrap=0 immediately; count resumes 1 on the first edge after release.
